pwm_generator: RTL and testbench

PWM_GENERATOR -- requirements
Module: pwm_generator

---
 rtl/pwm_generator.sv | 96 +++++++++
 tb/tb_pwm_generator.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pwm_generator.sv
// pwm_generator: center-aligned three-phase PWM with shadowed duty, dead time and fault shutdown.
module pwm_generator #(
  parameter int PWM_MAX   = 3000,
  parameter int DEAD_TIME = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] driver_pwm_data,
  input  logic        driver_pwm_valid,
  output logic        driver_pwm_ready,
  input  logic        fault,
  output logic [2:0]  gate_h,
  output logic [2:0]  gate_l,
  output logic        pulse_sense,
  output logic        pulse_period
);
  localparam logic [15:0] MAX = 16'(PWM_MAX);
  localparam logic [15:0] DT  = 16'(DEAD_TIME);
  logic [15:0]      r_cnt;
  logic             r_up;
  logic [2:0][15:0] r_duty;
  logic [2:0][15:0] r_shadow;
  logic [2:0][15:0] r_dt;
  logic [2:0]       r_st;
  logic             r_full;
  logic             r_hold;
  logic             w_up;
  logic             w_valley;
  logic             w_peak;
  logic             w_acc;
  logic             w_forced;
  logic             w_full_nx;
  logic [2:0]       w_des;
  logic [2:0][15:0] w_word;
  always_comb begin
    w_valley  = r_cnt == 16'd0;
    w_peak    = r_cnt == MAX;
    w_up      = w_valley ? 1'b1 : w_peak ? 1'b0 : r_up;
    w_acc     = driver_pwm_valid & driver_pwm_ready & ~fault;
    w_forced  = fault | r_hold;
    w_full_nx = w_acc | (r_full & ~w_valley);
    for (int i = 0; i < 3; i++) begin
      w_word[i] = driver_pwm_data[16*i +: 16] > MAX ? MAX : driver_pwm_data[16*i +: 16];
      w_des[i]  = r_cnt < r_duty[i];
    end
  end
  // Ready is held low during fault so no word is acknowledged and then wiped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt            <= '0;
      r_up             <= 1'b1;
      r_duty           <= '0;
      r_shadow         <= '0;
      r_full           <= 1'b0;
      r_hold           <= 1'b0;
      r_st             <= '0;
      r_dt             <= {3{DT}};
      gate_h           <= '0;
      gate_l           <= '0;
      pulse_sense      <= 1'b0;
      pulse_period     <= 1'b0;
      driver_pwm_ready <= 1'b0;
    end else begin
      r_cnt        <= w_up ? r_cnt + 16'd1 : r_cnt - 16'd1;
      r_up         <= w_up;
      pulse_sense  <= w_peak;
      pulse_period <= w_valley;
      if (fault) begin
        r_duty           <= '0;
        r_shadow         <= '0;
        r_full           <= 1'b0;
        r_hold           <= 1'b1;
        driver_pwm_ready <= 1'b0;
      end else begin
        if (w_valley & r_full) r_duty <= r_shadow;
        if (w_acc) r_shadow <= w_word;
        if (w_valley) r_hold <= 1'b0;
        r_full           <= w_full_nx;
        driver_pwm_ready <= ~w_full_nx;
      end
      // A desired-state change (or forced off) reloads the dead-time count; a side turns on once it expires.
      for (int i = 0; i < 3; i++) begin
        if (w_forced | (w_des[i] != r_st[i])) begin
          r_st[i]   <= w_des[i];
          r_dt[i]   <= DT;
          gate_h[i] <= 1'b0;
          gate_l[i] <= 1'b0;
        end else begin
          r_dt[i]   <= r_dt[i] == 16'd0 ? 16'd0 : r_dt[i] - 16'd1;
          gate_h[i] <= (r_dt[i] <= 16'd1) & r_st[i];
          gate_l[i] <= (r_dt[i] <= 16'd1) & ~r_st[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: randomized and directed checks of pwm_generator against a time-based reference model.
module tb_pwm_generator;
  localparam int M = 3000;
  localparam int D = 10;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic        fault = 1'b0;
  logic [47:0] data = '0;
  logic        ready;
  logic        sense;
  logic        period;
  logic [2:0]  gh;
  logic [2:0]  gl;
  pwm_generator #(.PWM_MAX(M), .DEAD_TIME(D)) dut (
    .clk(clk),
    .reset(reset),
    .driver_pwm_data(data),
    .driver_pwm_valid(valid),
    .driver_pwm_ready(ready),
    .fault(fault),
    .gate_h(gh),
    .gate_l(gl),
    .pulse_sense(sense),
    .pulse_period(period)
  );
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  int e;
  int m_duty[3];
  int m_shadow[3];
  int m_evt[3];
  int off_run[3];
  bit m_prev[3];
  bit m_full, m_hold, m_ready, m_sense, m_period, m_acc;
  logic [2:0] m_h, m_l;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Carrier value during the p-th clock after reset release: triangle 0..M..0.
  function automatic int tri_f(input int p);
    int q;
    q = p % (2 * M);
    return q <= M ? q : 2 * M - q;
  endfunction
  function automatic logic [15:0] rw();
    return $urandom_range(0, 7) == 0 ? 16'($urandom) : 16'($urandom_range(0, M + 200));
  endfunction
  task automatic model_init();
    e = 0;
    m_full = 0; m_hold = 0; m_ready = 0; m_sense = 0; m_period = 0; m_acc = 0;
    m_h = '0; m_l = '0;
    for (int i = 0; i < 3; i++) begin
      m_duty[i] = 0; m_shadow[i] = 0; m_evt[i] = 0; m_prev[i] = 0; off_run[i] = D;
    end
  endtask
  task automatic step();
    int cnt;
    bit forced, des, on;
    @(posedge clk);
    cnt = tri_f(e);
    e++;
    m_acc  = valid && m_ready && !fault;
    forced = fault || m_hold;
    for (int i = 0; i < 3; i++) begin
      des = cnt < m_duty[i];
      if (forced || des != m_prev[i]) m_evt[i] = e;
      m_prev[i] = des;
      on = !forced && (e - m_evt[i] >= D);
      m_h[i] = on && des;
      m_l[i] = on && !des;
    end
    m_sense  = cnt == M;
    m_period = cnt == 0;
    if (fault) begin
      for (int i = 0; i < 3; i++) begin m_duty[i] = 0; m_shadow[i] = 0; end
      m_full = 0;
      m_hold = 1;
    end else begin
      if (cnt == 0 && m_full) begin
        for (int i = 0; i < 3; i++) m_duty[i] = m_shadow[i];
        m_full = 0;
      end
      if (m_acc) begin
        for (int i = 0; i < 3; i++) m_shadow[i] = data[16*i +: 16] > M ? M : int'(data[16*i +: 16]);
        m_full = 1;
      end
      if (cnt == 0) m_hold = 0;
    end
    m_ready = !m_full && !fault;
    #1;
    chk("outputs", {gh, gl, sense, period, ready}, {m_h, m_l, m_sense, m_period, m_ready});
    chk("overlap", gh & gl, 3'b000);
    for (int i = 0; i < 3; i++) begin
      if (gh[i] | gl[i]) begin
        if (off_run[i] > 0) chk("dead_gap", off_run[i] >= D, 1);
        off_run[i] = 0;
      end else off_run[i]++;
    end
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask
  task automatic put(input logic [47:0] d);
    data  = d;
    valid = 1'b1;
    m_acc = 0;
    for (int k = 0; k < 7000 && !m_acc; k++) step();
    chk("accept", m_acc, 1);
    valid = 1'b0;
  endtask
  task automatic release_check(input string tag);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    model_init();
    step();
    chk({tag, "_ready"}, ready, 1'b1);
    chk({tag, "_gate_off"}, {gh, gl}, 6'b0);
    for (int k = 0; k < D - 2; k++) begin
      step();
      chk({tag, "_gate_off"}, {gh, gl}, 6'b0);
    end
  endtask
  initial begin
    #2;
    reset = 1'b1;
    #1;
    chk("rst_state", {gh, gl, sense, period, ready}, 9'b0);
    release_check("rst");
    put({16'd1500, 16'd1500, 16'd1500});
    run(9000);
    put({16'd0, 16'd3000, 16'd4000});
    run(9000);
    put({16'd500, 16'd1000, 16'd2500});
    data  = {16'd2800, 16'd100, 16'd3000};
    valid = 1'b1;
    step();
    chk("stall_ready", ready, 1'b0);
    put({16'd2800, 16'd100, 16'd3000});
    run(9000);
    put({16'd2000, 16'd2000, 16'd2000});
    run(8000);
    fault = 1'b1;
    step();
    chk("fault_off", {gh, gl}, 6'b0);
    run(200);
    fault = 1'b0;
    run(8000);
    for (int k = 0; k < 30000; k++) begin
      if (!valid || m_acc) begin
        valid = $urandom_range(0, 3) != 0;
        data  = {rw(), rw(), rw()};
      end
      step();
    end
    valid = 1'b0;
    for (int k = 0; k < 2 * M && tri_f(e) != 1234; k++) step();
    chk("reach_1234", tri_f(e), 1234);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid", {gh, gl, sense, period, ready}, 9'b0);
    release_check("rst_mid");
    run(100);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
